// File: rtl/priority_encoder_scan.sv
// Registered priority scanner: captures a request vector and emits the index of
// every set bit, one per beat, in priority order with last/none/remaining flags.
module priority_encoder_scan #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic [CNT_W-1:0] out_remain
);

  typedef enum logic { IDLE = 1'b0, SCAN = 1'b1 } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             zflag, zflag_n;
  logic [IDX_W-1:0] idx_c;
  logic [CNT_W-1:0] cnt_c;
  logic             scan;
  logic [WIDTH-1:0] clr_mask;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] highest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Output decode is driven from pend only; reset forces every output low.
  always_comb begin
    idx_c      = (MSB_FIRST != 0) ? highest_set(pend) : lowest_set(pend);
    cnt_c      = popcount(pend);
    scan       = (state == SCAN) && !rst;
    out_valid  = scan;
    out_none   = scan && zflag;
    out_idx    = rst ? '0 : idx_c;
    out_remain = rst ? '0 : cnt_c;
    out_last   = scan && (cnt_c <= CNT_W'(1));
    in_ready   = !rst && ((state == IDLE) || (scan && out_last && out_ready));
  end

  // A new capture takes precedence over the clear of the final beat, which
  // is what lets back-to-back vectors run without a bubble.
  always_comb begin
    state_n  = state;
    pend_n   = pend;
    zflag_n  = zflag;
    clr_mask = '0;
    clr_mask[idx_c] = 1'b1;
    if (out_valid && out_ready) begin
      pend_n = pend & ~clr_mask;
      if (out_last) state_n = IDLE;
    end
    if (in_valid && in_ready) begin
      pend_n  = in_vec;
      zflag_n = (in_vec == '0);
      state_n = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      zflag <= zflag_n;
    end
  end

endmodule
